cascade_counter: RTL and testbench
==================================

# cascade_counter

Parametrised chain of modulo counters, the next generation of the team's single-stage carry counter. It has `STAGES` digits of `WIDTH` bits each, and each digit has its own runtime limit. The block supports up/down counting, synchronous load and clear, and whole-chain wrap reporting. It is intended for the timer, clock-display and event-divider paths in the NPC peripherals, where one instance replaces a hand-wired chain of single counters.

## Interface
- `STAGES`, default 4: number of digits in the chain, minimum 1.
- `WIDTH`, default 4: bits per digit.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `en` in 1: step request for digit 0.
- `dir` in 1: 1 = count up, 0 = count down. Applies to all digits.
- `clr` in 1: synchronous clear of all digits to 0.
- `load` in 1: synchronous parallel load.
- `load_val` in `STAGES*WIDTH`: load data. Digit i is bits `[i*WIDTH +: WIDTH]`.
- `limit` in `STAGES*WIDTH`: per-digit maximum value, packed like `load_val`.
- `ovf_clr` in 1: clears `ovf_sticky`.
- `count` out `STAGES*WIDTH`: registered digit values, packed like `load_val`.
- `carry` out `STAGES`: combinational per-digit carry (up) or borrow (down) for the current cycle.
- `wrap` out 1: registered one-cycle pulse; the whole chain wrapped in the previous cycle.
- `ovf_sticky` out 1: registered flag, set on any chain wrap.

## Operation
- **Priority per cycle:** `clr` > `load` > step > hold.
- **`clr`:** all digits become 0. `carry` is all 0. `wrap` is not generated. `ovf_sticky` is cleared.
- **`load`:** every digit takes its `load_val` field unclamped, even if it exceeds `limit`. `carry` is all 0.
- **Step enable:** digit 0 steps when `en`=1. Digit i>0 steps when `carry[i-1]`=1. `carry[i]` can be 1 only if digit i steps.
- **Up step, digit value c, limit L:**
  - c >= L: next value 0, `carry[i]`=1.
  - otherwise: next value c+1, `carry[i]`=0.
- **Down step:**
  - c == 0: next value L, `carry[i]`=1.
  - c > L: next value L, `carry[i]`=0.
  - otherwise: next value c-1, `carry[i]`=0.
- **L = 0:** the digit stays at 0 and asserts `carry` on every step.
- **Arithmetic:** all arithmetic is `WIDTH` bits and unsigned. Increment never overflows, because c < L <= 2^WIDTH-1.
- **Chain wrap:** `carry[STAGES-1]`=1 in a cycle. It sets `wrap` for the next cycle and sets `ovf_sticky`.
- **`ovf_sticky`:** holds until `ovf_clr` or `clr`. If `ovf_clr` and a chain wrap occur in the same cycle, set wins.
- **Mid-operation changes:** `limit` and `dir` may change at any cycle and take effect the same cycle. No internal state other than `count`, `wrap` and `ovf_sticky` exists.

## Timing
- **Reset:** `rst` low asynchronously forces `count`=0, `wrap`=0 and `ovf_sticky`=0, independent of `clk`. Deassertion is synchronised externally. The first step occurs on the first rising edge with `rst` high.
- **Latency:**
  - `count` updates on the edge after `en`/`clr`/`load` is sampled (1 cycle).
  - `carry` is combinational from `count`, `en`, `dir`, `limit`, `clr` and `load`: 0 cycles.
  - `wrap` follows the cycle in which `carry[STAGES-1]` is high by 1 cycle and lasts exactly 1 cycle.
- **Ripple:** carry ripples through all digits in one cycle. The combinational path is STAGES comparators deep, which is acceptable for STAGES <= 8 at the NPC clock.
- **Throughput:** one step per cycle sustained. With `en` held high, the chain period is the product of (L_i+1).

## Test plan
- **Up count.** STAGES=2, WIDTH=4, limit={5,9}, `dir`=1, `en`=1 for 61 cycles from reset.
  - `count` runs 0x00..0x09, 0x10..0x59.
  - At 0x59, `carry`=2'b11.
  - Next cycle `count`=0x00 and `wrap`=1 for one cycle.
  - `ovf_sticky`=1 and stays 1.
- **Down wrap.** Same limits, `dir`=0, `count`=0x00, `en`=1 for one cycle.
  - `carry`=2'b11 in that cycle.
  - Next `count`=0x59 and `wrap`=1.
- **Load and clear priority.**
  - `load`=1, `load_val`=0x37, `en`=1: next `count`=0x37, `carry`=0 in the load cycle.
  - `clr`=1 with `load`=1: next `count`=0x00 and `ovf_sticky`=0.
- **Zero limit.** limit={9,0}, `en`=1, up.
  - `carry[0]`=1 every cycle.
  - Digit 1 increments every cycle: 1, 2, ..., 9, then 0 with `wrap` the following cycle.
- **Over-limit value.** Load digit0=12, limit0=9.
  - Up step: digit0=0 and `carry[0]`=1.
  - Reload 12, down step: digit0=9 and `carry[0]`=0.
- **Async reset mid-count.** `count`=0x47, `ovf_sticky`=1; drive `rst` low between edges.
  - `count`=0 and `ovf_sticky`=0 immediately, before the next edge.
  - Count resumes from 0x00 after release.

Source files
------------

// File: rtl/cascade_counter.sv
// Chain of STAGES modulo digits with per-digit runtime limits, up/down stepping,
// rippled carry/borrow, sync clear/load and registered chain-wrap reporting.
module cascade_counter #(
  parameter int STAGES = 4,
  parameter int WIDTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      dir,
  input  logic                      clr,
  input  logic                      load,
  input  logic [STAGES*WIDTH-1:0]   load_val,
  input  logic [STAGES*WIDTH-1:0]   limit,
  input  logic                      ovf_clr,
  output logic [STAGES*WIDTH-1:0]   count,
  output logic [STAGES-1:0]         carry,
  output logic                      wrap,
  output logic                      ovf_sticky
);

  logic [STAGES-1:0][WIDTH-1:0] r_count;
  logic                         r_wrap;
  logic                         r_ovf;

  logic [STAGES-1:0][WIDTH-1:0] w_limit;
  logic [STAGES-1:0][WIDTH-1:0] w_load_val;
  logic [STAGES-1:0][WIDTH-1:0] w_next;
  logic [STAGES-1:0]            w_step;
  logic [STAGES-1:0]            w_carry;
  logic [WIDTH-1:0]             w_stepped;
  logic                         w_ripple;
  logic                         w_at_top;
  logic                         w_at_zero;
  logic                         w_chain_wrap;

  assign w_limit    = limit;
  assign w_load_val = load_val;

  // Carry ripples digit by digit; clr/load suppress stepping entirely so carry stays 0.
  always_comb begin
    w_next    = r_count;
    w_step    = '0;
    w_carry   = '0;
    w_stepped = '0;
    w_at_top  = 1'b0;
    w_at_zero = 1'b0;
    w_ripple  = en & ~clr & ~load;
    for (int i = 0; i < STAGES; i++) begin
      w_step[i] = w_ripple;
      w_at_top  = (r_count[i] >= w_limit[i]);
      w_at_zero = (r_count[i] == '0);
      if (dir) begin
        w_carry[i] = w_step[i] & w_at_top;
        w_stepped  = w_at_top ? '0 : r_count[i] + WIDTH'(1);
      end else begin
        w_carry[i] = w_step[i] & w_at_zero;
        if (w_at_zero || (r_count[i] > w_limit[i]))
          w_stepped = w_limit[i];
        else
          w_stepped = r_count[i] - WIDTH'(1);
      end
      if (clr)
        w_next[i] = '0;
      else if (load)
        w_next[i] = w_load_val[i];
      else if (w_step[i])
        w_next[i] = w_stepped;
      else
        w_next[i] = r_count[i];
      w_ripple = w_carry[i];
    end
  end

  assign w_chain_wrap = w_carry[STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_next;
      r_wrap  <= w_chain_wrap;
      // A wrap in the same cycle as ovf_clr keeps the flag set.
      if (clr)
        r_ovf <= 1'b0;
      else if (w_chain_wrap)
        r_ovf <= 1'b1;
      else if (ovf_clr)
        r_ovf <= 1'b0;
    end
  end

  assign count      = r_count;
  assign carry      = w_carry;
  assign wrap       = r_wrap;
  assign ovf_sticky = r_ovf;

endmodule

// File: tb/tb_cascade_counter.sv
// Table-driven bench for cascade_counter (2 digits x 4 bits) with a queue of
// expected post-edge results checked after each clock edge.
module tb_cascade_counter;

  localparam int STAGES = 2;
  localparam int WIDTH  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, dir = 1'b1, clr = 1'b0, load = 1'b0, ovf_clr = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] limit = 8'h59;
  logic [7:0] count;
  logic [1:0] carry;
  logic       wrap, ovf_sticky;

  cascade_counter #(.STAGES(STAGES), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .limit(limit), .ovf_clr(ovf_clr),
    .count(count), .carry(carry), .wrap(wrap), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       clr, load, en, dir, oc;
    logic [7:0] lv, lim;
    logic [1:0] e_carry;
    logic [7:0] e_count;
    logic       e_wrap, e_ovf;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] cnt;
    logic       wrp, ovf;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(string n, logic c, logic ld, logic e, logic d, logic oc,
                              logic [7:0] lv, logic [7:0] lim, logic [1:0] ec,
                              logic [7:0] ecnt, logic ew, logic eo);
    vec_t v;
    v.name = n; v.clr = c; v.load = ld; v.en = e; v.dir = d; v.oc = oc;
    v.lv = lv; v.lim = lim; v.e_carry = ec; v.e_count = ecnt; v.e_wrap = ew; v.e_ovf = eo;
    return v;
  endfunction

  task automatic chk(string n, logic [7:0] act, logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", n, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    exp_t e;
    @(negedge clk);
    clr = v.clr; load = v.load; en = v.en; dir = v.dir; ovf_clr = v.oc;
    load_val = v.lv; limit = v.lim;
    #1;
    chk({v.name, " carry"}, {6'd0, carry}, {6'd0, v.e_carry});
    e.name = v.name; e.cnt = v.e_count; e.wrp = v.e_wrap; e.ovf = v.e_ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_miss++;
      $display("FAIL scoreboard empty at %s", v.name);
    end else begin
      e = sb.pop_front();
      chk({e.name, " count"}, count, e.cnt);
      chk({e.name, " wrap"}, {7'd0, wrap}, {7'd0, e.wrp});
      chk({e.name, " ovf"}, {7'd0, ovf_sticky}, {7'd0, e.ovf});
    end
  endtask

  initial begin
    logic [7:0] cur, nxt;
    logic       c0, c1;

    // Up count through the whole 6x10 chain
    for (int k = 0; k < 60; k++) begin
      cur = {4'(k / 10), 4'(k % 10)};
      nxt = {4'(((k + 1) % 60) / 10), 4'((k + 1) % 10)};
      c0  = (k % 10 == 9);
      c1  = c0 && (k / 10 == 5);
      tbl.push_back(mk($sformatf("up%0d", k), 0, 0, 1, 1, 0, 8'h00, 8'h59,
                       {c1, c0}, nxt, c1, (k == 59)));
    end
    tbl.push_back(mk("hold_after_wrap", 0, 0, 0, 1, 0, 8'h00, 8'h59, 2'b00, 8'h00, 0, 1));
    tbl.push_back(mk("down_wrap",      0, 0, 1, 0, 0, 8'h00, 8'h59, 2'b11, 8'h59, 1, 1));
    tbl.push_back(mk("down_step",      0, 0, 1, 0, 0, 8'h00, 8'h59, 2'b00, 8'h58, 0, 1));
    tbl.push_back(mk("load_over_en",   0, 1, 1, 1, 0, 8'h37, 8'h59, 2'b00, 8'h37, 0, 1));
    tbl.push_back(mk("clr_over_load",  1, 1, 1, 1, 0, 8'h22, 8'h59, 2'b00, 8'h00, 0, 0));
    tbl.push_back(mk("down_wrap2",     0, 0, 1, 0, 0, 8'h00, 8'h59, 2'b11, 8'h59, 1, 1));
    tbl.push_back(mk("ovf_clr",        0, 0, 0, 1, 1, 8'h00, 8'h59, 2'b00, 8'h59, 0, 0));
    tbl.push_back(mk("ovf_set_wins",   0, 0, 1, 1, 1, 8'h00, 8'h59, 2'b11, 8'h00, 1, 1));
    // Zero limit on digit 0: digit 1 steps every cycle
    tbl.push_back(mk("zl_clr",         1, 0, 0, 1, 0, 8'h00, 8'h90, 2'b00, 8'h00, 0, 0));
    for (int j = 0; j < 10; j++) begin
      nxt = {4'((j + 1) % 10), 4'h0};
      c1  = (j == 9);
      tbl.push_back(mk($sformatf("zl%0d", j), 0, 0, 1, 1, 0, 8'h00, 8'h90,
                       {c1, 1'b1}, nxt, c1, c1));
    end
    tbl.push_back(mk("zl_hold",        0, 0, 0, 1, 0, 8'h00, 8'h90, 2'b00, 8'h00, 0, 1));
    // Over-limit digit behaviour
    tbl.push_back(mk("ol_clr",         1, 0, 0, 1, 0, 8'h00, 8'h59, 2'b00, 8'h00, 0, 0));
    tbl.push_back(mk("ol_load",        0, 1, 0, 1, 0, 8'h0C, 8'h59, 2'b00, 8'h0C, 0, 0));
    tbl.push_back(mk("ol_up",          0, 0, 1, 1, 0, 8'h00, 8'h59, 2'b01, 8'h10, 0, 0));
    tbl.push_back(mk("ol_reload",      0, 1, 0, 0, 0, 8'h0C, 8'h59, 2'b00, 8'h0C, 0, 0));
    tbl.push_back(mk("ol_down",        0, 0, 1, 0, 0, 8'h00, 8'h59, 2'b00, 8'h09, 0, 0));
    // Set up 0x47 with sticky flag for the reset test
    tbl.push_back(mk("ar_clr",         1, 0, 0, 1, 0, 8'h00, 8'h59, 2'b00, 8'h00, 0, 0));
    tbl.push_back(mk("ar_wrap",        0, 0, 1, 0, 0, 8'h00, 8'h59, 2'b11, 8'h59, 1, 1));
    tbl.push_back(mk("ar_load",        0, 1, 0, 1, 0, 8'h47, 8'h59, 2'b00, 8'h47, 0, 1));

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset count", count, 8'h00);
    chk("reset wrap", {7'd0, wrap}, 8'h00);
    chk("reset ovf", {7'd0, ovf_sticky}, 8'h00);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Async reset between edges
    @(negedge clk);
    load = 1'b0; en = 1'b0; clr = 1'b0; ovf_clr = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_rst count", count, 8'h47);
    rst = 1'b0;
    #1;
    chk("async_rst count", count, 8'h00);
    chk("async_rst ovf", {7'd0, ovf_sticky}, 8'h00);
    chk("async_rst wrap", {7'd0, wrap}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    apply(mk("resume_up", 0, 0, 1, 1, 0, 8'h00, 8'h59, 2'b00, 8'h01, 0, 0));

    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard leftover: got %0d entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
